idp_enc_11: RTL and testbench

//  Sequential FNS (Fibonacci numeral system) encoder for the 11-wire IDP CAC link: transmit-side inverse of the 11-bit IDP decoder.

---
 rtl/idp_enc_11.sv | 165 ++++++++++++++++
 tb/tb_idp_enc_11.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/idp_enc_11.sv
// Sequential FNS encoder for the 11-wire IDP CAC link: greedy weight subtraction, one weight per clock.
// Optional IDP_ENC_SELFCHK_EN adds chk_err, a recombine-and-compare check on each finished word.

`ifndef FNS01
`define FNS01 1
`endif
`ifndef FNS02
`define FNS02 2
`endif
`ifndef FNS03
`define FNS03 3
`endif
`ifndef FNS04
`define FNS04 5
`endif
`ifndef FNS05
`define FNS05 8
`endif
`ifndef FNS06
`define FNS06 13
`endif
`ifndef FNS07
`define FNS07 21
`endif
`ifndef FNS08
`define FNS08 34
`endif
`ifndef FNS10
`define FNS10 55
`endif
`ifndef FNS11
`define FNS11 89
`endif
`ifndef IBLEN11
`define IBLEN11 9
`endif

module idp_enc_11 #(
  parameter int DW   = `IBLEN11,
  parameter int WMAX = `FNS10 + 2*`FNS11 + `FNS08 + `FNS07 + `FNS06 + `FNS05
                     + `FNS04 + `FNS03 + `FNS02 + `FNS01
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [10:0]   codeout,
  output logic          ovf
`ifdef IDP_ENC_SELFCHK_EN
  ,output logic         chk_err
`endif
);

  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;
  state_t state, state_nxt;

  logic [DW-1:0] rem;
  logic [3:0]    step;
  logic [3:0]    sb;
  logic [DW-1:0] sw;
  logic          in_rng;

  function automatic logic [DW-1:0] wt(input logic [3:0] b);
    case (b)
      4'd10:       wt = DW'(`FNS10);
      4'd9, 4'd8:  wt = DW'(`FNS11);
      4'd7:        wt = DW'(`FNS08);
      4'd6:        wt = DW'(`FNS07);
      4'd5:        wt = DW'(`FNS06);
      4'd4:        wt = DW'(`FNS05);
      4'd3:        wt = DW'(`FNS04);
      4'd2:        wt = DW'(`FNS03);
      4'd1:        wt = DW'(`FNS02);
      default:     wt = DW'(`FNS01);
    endcase
  endfunction

  // The two FNS11 wires outrank FNS10, so the first three steps are out of bit order.
  function automatic logic [3:0] step_bit(input logic [3:0] s);
    case (s)
      4'd0:    step_bit = 4'd9;
      4'd1:    step_bit = 4'd8;
      4'd2:    step_bit = 4'd10;
      default: step_bit = 4'd10 - s;
    endcase
  endfunction

  assign sb       = step_bit(step);
  assign sw       = wt(sb);
  assign in_rng   = (din <= DW'(WMAX));
  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = in_rng ? ENC : DONE;
      ENC:  if (step == 4'd10) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      codeout   <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      rem       <= '0;
      step      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (in_rng) begin
            rem     <= din;
            codeout <= '0;
            step    <= '0;
            ovf     <= 1'b0;
          end else begin
            codeout   <= 11'h7FF;
            ovf       <= 1'b1;
            out_valid <= 1'b1;
          end
        end
        ENC: begin
          if (rem >= sw) begin
            codeout[sb] <= 1'b1;
            rem         <= rem - sw;
          end
          step <= step + 4'd1;
          if (step == 4'd10) out_valid <= 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef IDP_ENC_SELFCHK_EN
  logic [DW-1:0] din_q;
  logic [DW:0]   recomb;

  always_ff @(posedge clk) begin
    if (rst)                       din_q <= '0;
    else if (state == IDLE && in_valid) din_q <= din;
  end

  always_comb begin
    recomb = '0;
    for (int i = 0; i < 11; i++)
      if (codeout[i]) recomb = recomb + {1'b0, wt(4'(i))};
  end

  // Combinational so it tracks out_valid exactly and drops on handoff.
  assign chk_err = (state == DONE) && !ovf && (recomb != {1'b0, din_q});
`endif

endmodule

// File: tb/tb_idp_enc_11.sv
// Randomised bench for idp_enc_11 against a greedy FNS reference model plus literal spot checks.
module tb_idp_enc_11;
  localparam int DW   = 9;
  localparam int WMAX = 320;
  // descending weight order, ties to the higher wire
  localparam int WV[11] = '{89, 89, 55, 34, 21, 13, 8, 5, 3, 2, 1};
  localparam int BP[11] = '{9, 8, 10, 7, 6, 5, 4, 3, 2, 1, 0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] din = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [10:0]   codeout;
  logic          ovf;
`ifdef IDP_ENC_SELFCHK_EN
  logic          chk_err;
`endif

  int  npass = 0, ntot = 0;
  bit  rnd_rdy = 1'b0;

  always #5 clk = ~clk;

  idp_enc_11 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .codeout(codeout), .ovf(ovf)
`ifdef IDP_ENC_SELFCHK_EN
    , .chk_err(chk_err)
`endif
  );

  task automatic chk(input string nm, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
  endtask

  function automatic int greedy(input int v);
    int r = v, c = 0;
    for (int i = 0; i < 11; i++)
      if (r >= WV[i]) begin r -= WV[i]; c |= (1 << BP[i]); end
    return c;
  endfunction

  function automatic int recomb(input int c);
    int s = 0;
    for (int i = 0; i < 11; i++)
      if (c[BP[i]]) s += WV[i];
    return s;
  endfunction

  // Reference model: state as it will be after the next rising edge.
  bit busy = 1'b0;
  int cnt = 0, lat = 0, exp_code = 0, din_m = 0;
  bit exp_ovf = 1'b0, prev_rst = 1'b0;

  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(!busy && !rst));
    if (busy && cnt >= lat) begin
      chk("out_valid_hi", int'(out_valid), 1);
      chk("codeout", int'(codeout), exp_code);
      chk("ovf", int'(ovf), int'(exp_ovf));
      if (!exp_ovf) chk("recomb", recomb(int'(codeout)), din_m);
`ifdef IDP_ENC_SELFCHK_EN
      chk("chk_err", int'(chk_err), 0);
`endif
    end else begin
      chk("out_valid_lo", int'(out_valid), 0);
    end
    if (prev_rst) begin
      chk("rst_codeout", int'(codeout), 0);
      chk("rst_ovf", int'(ovf), 0);
    end
    prev_rst = rst;
    if (rst) busy = 1'b0;
    else if (busy) begin
      if (cnt >= lat && out_ready) busy = 1'b0;
      else if (cnt < lat) cnt++;
    end else if (in_valid) begin
      busy     = 1'b1;
      cnt      = 0;
      din_m    = int'(din);
      exp_ovf  = (din_m > WMAX);
      lat      = exp_ovf ? 0 : 11;
      exp_code = exp_ovf ? 'h7FF : greedy(din_m);
    end
  end

  always @(posedge clk) begin
    #2;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Call at posedge+#1; returns at posedge+#1 just after the accept edge.
  task automatic send(input logic [DW-1:0] d, input bit junk);
    int t = 0;
    while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin chk("in_ready_timeout", 0, 1); return; end
    in_valid = 1'b1; din = d;
    @(posedge clk); #1;
    if (junk) repeat (5) begin din = DW'($urandom); @(posedge clk); #1; end
    in_valid = 1'b0; din = DW'($urandom);
  endtask

  task automatic lit(input int d, input int ec, input int eo, input int el);
    int k = 0;
    send(DW'(d), 1'b0);
    while (!out_valid && k < 40) begin @(posedge clk); #1; k++; end
    chk($sformatf("lat_%0d", d), k, el);
    chk($sformatf("code_%0d", d), int'(codeout), ec);
    chk($sformatf("ovf_%0d", d), int'(ovf), eo);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_codeout", int'(codeout), 0);
    chk("reset_ovf", int'(ovf), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    rst = 1'b0; #1;
    chk("post_reset_in_ready", int'(in_ready), 1);

    chk("model_0", greedy(0), 'h000);
    chk("model_34", greedy(34), 'h080);
    chk("model_178", greedy(178), 'h300);
    chk("model_55", greedy(55), 'h400);
    chk("model_320", greedy(320), 'h7FF);
    chk("model_recomb", recomb('h214), 100);

    lit(0,   'h000, 0, 11);
    lit(34,  'h080, 0, 11);
    lit(178, 'h300, 0, 11);
    lit(55,  'h400, 0, 11);
    lit(320, 'h7FF, 0, 11);
    lit(321, 'h7FF, 1, 0);
    lit(511, 'h7FF, 1, 0);

    // reset sampled on the edge that would process step 5
    send(DW'(200), 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midenc_rst_out_valid", int'(out_valid), 0);
    chk("midenc_rst_codeout", int'(codeout), 0);
    chk("midenc_rst_in_ready", int'(in_ready), 0);
    rst = 1'b0; #1;
    chk("midenc_rel_in_ready", int'(in_ready), 1);
    lit(100, 'h214, 0, 11);

    rnd_rdy = 1'b1;
    for (int d = 0; d <= WMAX; d++) send(DW'(d), 1'b1);
    repeat (20) send(DW'($urandom), 1'b0);
    repeat (40) @(posedge clk);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
